magnitude_scheduler: RTL and testbench
======================================

Name: magnitude_scheduler

Overview:
Round-robin scheduler that shares one pipelined magnitude unit among NUM_CHANNELS requesters, such as several input_1/input_2 stream pairs.
- Accepts at most one sample pair per cycle via a valid/ready handshake and issues it to the magnitude unit.
- Tags each issued pair with its channel ID in an order-preserving tag FIFO.
- Routes each returned magnitude to the owning channel.
- Sits between the per-channel stream front-ends and the single magnitude instance.

Parameters:
- NUM_CHANNELS, 4, number of requesters (2..16).
- INPUT_BITS, 16, width of each unsigned operand.
- OUTPUT_BITS, INPUT_BITS+1, magnitude result width.
- TAG_FIFO_DEPTH, 32, maximum in-flight samples; power of two and at least the magnitude latency.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low; all state clears while rst=0.
- sched_en  in  1  when 0, no new grants are made; in-flight results still drain.
- req_valid  in  NUM_CHANNELS  per-channel request valid.
- req_ready  out  NUM_CHANNELS  per-channel accept; one-hot or zero.
- req_input_1  in  NUM_CHANNELS*INPUT_BITS  packed operand 1; channel c occupies bits [c*INPUT_BITS +: INPUT_BITS].
- req_input_2  in  NUM_CHANNELS*INPUT_BITS  packed operand 2, same packing.
- mag_input_ready  out  1  issue strobe to the magnitude unit.
- mag_input_1  out  INPUT_BITS  operand 1 to the magnitude unit.
- mag_input_2  out  INPUT_BITS  operand 2 to the magnitude unit.
- mag_output_ready  in  1  result strobe from the magnitude unit.
- mag_output_1  in  OUTPUT_BITS  magnitude result.
- res_valid  out  NUM_CHANNELS  one-hot result strobe.
- res_data  out  OUTPUT_BITS  routed result.
- res_channel  out  $clog2(NUM_CHANNELS)  channel of res_data.
- idle  out  1  tag FIFO empty and no issue pending.
- err_underflow  out  1  sticky; a result arrived with the tag FIFO empty.

Behaviour:
- Reset values: all outputs 0 except idle=1; round-robin pointer=0; FIFO count=0.
- Grant condition (combinational): sched_en=1, tag count < TAG_FIFO_DEPTH, and at least one req_valid.
  - Granted channel g is the first valid channel at or after the pointer, wrapping mod NUM_CHANNELS.
  - req_ready[g]=1 in that cycle only; all other req_ready bits are 0.
  - req_ready must not depend combinationally on req_ready-derived feedback or on mag_output_ready.
- Accept: the transfer occurs at the clock edge where req_valid[g]=1 and req_ready[g]=1. On that edge:
  - mag_input_1 and mag_input_2 are registered from channel g, and mag_input_ready=1 for the following cycle.
  - g is pushed into the tag FIFO.
  - The pointer becomes (g+1) mod NUM_CHANNELS.
- No accept: mag_input_ready=0 next cycle; mag_input_1/mag_input_2 hold their previous values; the pointer is unchanged.
- Issue latency: 1 cycle from accept edge to mag_input_ready. Throughput: 1 pair per cycle.
- Return: on an edge with mag_output_ready=1 and the FIFO non-empty:
  - pop tag t;
  - next cycle res_valid=(1<<t), res_data=mag_output_1, res_channel=t.
  - Otherwise res_valid=0, and res_data/res_channel hold.
  - Return latency: 1 cycle.
- Full: count==TAG_FIFO_DEPTH forces all req_ready to 0, even if a pop occurs in the same cycle. Readiness resumes the cycle after count drops.
- Simultaneous push and pop: count unchanged; the FIFO read and write pointers wrap independently mod depth.
- Underflow: mag_output_ready=1 with count==0:
  - the result is dropped and res_valid stays 0;
  - err_underflow is set and holds until reset.
- sched_en falling mid-stream: accepts stop the same cycle; queued tags continue to pop normally.
- idle = (count==0) && !mag_input_ready.
- Reset mid-operation: all state clears immediately and asynchronously, including tags. The magnitude unit must share the same reset so no stale results return. Any result that still returns raises err_underflow.
- Result ordering relies on the magnitude unit being in-order with fixed latency; no reordering is performed.

Decomposition:
- Package magnitude_sched_pkg contains:
  - the default constants NUM_CHANNELS_DEF and TAG_FIFO_DEPTH_DEF;
  - the function chan_w(n) = max(1, $clog2(n));
  - the typedef chan_id_t for the tag.
- One sub-module, magnitude_tag_fifo: synchronous FIFO with push, pop, dout, count, full and empty.
- The round-robin arbiter stays inline.

Test Plan:
- Only channel 0 valid with (3,4), driving a real magnitude instance: one accept, mag_input_ready pulses once, then res_valid=4'b0001, res_data=5, res_channel=0.
- All 4 channels continuously valid with pairs (5,12), (8,15), (0,0), (65535,0): grants in order 0,1,2,3,0,...; results 13, 17, 0, 65535 arrive on channels 0,1,2,3 in order, one per cycle.
- Channels 2 and 3 always valid, channel 0 valid in random bursts: no valid channel waits more than NUM_CHANNELS-1 cycles for req_ready; the accept count per channel differs by at most 1 over each full rotation.
- Stub magnitude with outputs held off, TAG_FIFO_DEPTH=4: exactly 4 accepts, then req_ready=0. One mag_output_ready pulse gives exactly one further accept the cycle after the pop.
- mag_output_ready pulsed with an empty FIFO: err_underflow=1 and stays 1 afterwards; res_valid remains 0.
- Assert rst=0 with 3 samples in flight and sched_en=1:
  - outputs immediately become 0 and idle=1;
  - after release, channels 1 and 2 both valid: channel 1 is granted first, then channel 2.

Source files
------------

// File: rtl/magnitude_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | magnitude_sched_pkg                                                        |
// | Shared constants, helper function and tag type for the magnitude scheduler.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package magnitude_sched_pkg;

    localparam int NUM_CHANNELS_DEF   = 4;
    localparam int TAG_FIFO_DEPTH_DEF = 32;
    localparam int CHAN_ID_MAX_W      = 4;

    // Channel-ID width; a single requester still needs one bit of tag
    function automatic int chan_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Wide enough for the largest supported channel count (16)
    typedef logic [CHAN_ID_MAX_W-1:0] chan_id_t;

endpackage
`default_nettype wire

// File: rtl/magnitude_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | magnitude_tag_fifo                                                         |
// | Order-preserving FIFO of channel tags for in-flight magnitude samples.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module magnitude_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Tags are cleared too so nothing stale survives a reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/magnitude_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | magnitude_scheduler                                                        |
// | Round-robin sharing of one in-order magnitude pipeline among N requesters. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module magnitude_scheduler
    import magnitude_sched_pkg::*;
#(
    parameter int NUM_CHANNELS   = NUM_CHANNELS_DEF,
    parameter int INPUT_BITS     = 16,
    parameter int OUTPUT_BITS    = INPUT_BITS + 1,
    parameter int TAG_FIFO_DEPTH = TAG_FIFO_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sched_en,
    input  logic [NUM_CHANNELS-1:0]            req_valid,
    output logic [NUM_CHANNELS-1:0]            req_ready,
    input  logic [NUM_CHANNELS*INPUT_BITS-1:0] req_input_1,
    input  logic [NUM_CHANNELS*INPUT_BITS-1:0] req_input_2,
    output logic                               mag_input_ready,
    output logic [INPUT_BITS-1:0]              mag_input_1,
    output logic [INPUT_BITS-1:0]              mag_input_2,
    input  logic                               mag_output_ready,
    input  logic [OUTPUT_BITS-1:0]             mag_output_1,
    output logic [NUM_CHANNELS-1:0]            res_valid,
    output logic [OUTPUT_BITS-1:0]             res_data,
    output logic [$clog2(NUM_CHANNELS)-1:0]    res_channel,
    output logic                               idle,
    output logic                               err_underflow
);

    localparam int CW   = chan_w(NUM_CHANNELS);
    localparam int CNTW = $clog2(TAG_FIFO_DEPTH) + 1;

    logic [CW-1:0]           r_ptr;
    logic                    r_mag_rdy;
    logic [INPUT_BITS-1:0]   r_mag_in1;
    logic [INPUT_BITS-1:0]   r_mag_in2;
    logic [NUM_CHANNELS-1:0] r_res_valid;
    logic [OUTPUT_BITS-1:0]  r_res_data;
    logic [CW-1:0]           r_res_chan;
    logic                    r_err;

    logic [NUM_CHANNELS-1:0] w_rot;
    logic [CW:0]             w_sum;
    logic [CW-1:0]           w_grant;
    logic                    w_found;
    logic                    w_grant_ok;
    logic                    w_accept;
    logic                    w_pop;
    logic [CW-1:0]           w_tag;
    logic [CNTW-1:0]         w_count;
    logic                    w_full;
    logic                    w_empty;

    // Rotate so bit i is channel (ptr+i) mod N; the first set bit wins
    always_comb begin
        w_rot   = NUM_CHANNELS'({req_valid, req_valid} >> r_ptr);
        w_sum   = '0;
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (CW+1)'(i);
                if (w_sum >= (CW+1)'(NUM_CHANNELS)) begin
                    w_sum = w_sum - (CW+1)'(NUM_CHANNELS);
                end
                w_grant = w_sum[CW-1:0];
            end
        end
    end

    // Full is judged on the current count, so a same-cycle pop cannot free a slot
    assign w_grant_ok = sched_en && !w_full && w_found;
    assign req_ready  = w_grant_ok ? (NUM_CHANNELS'(1) << w_grant) : '0;
    assign w_accept   = |(req_valid & req_ready);
    assign w_pop      = mag_output_ready && !w_empty;

    magnitude_tag_fifo #(
        .DEPTH (TAG_FIFO_DEPTH),
        .WIDTH (CW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .din   (w_grant),
        .pop   (w_pop),
        .dout  (w_tag),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_mag_rdy   <= 1'b0;
            r_mag_in1   <= '0;
            r_mag_in2   <= '0;
            r_res_valid <= '0;
            r_res_data  <= '0;
            r_res_chan  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_mag_rdy <= w_accept;
            if (w_accept) begin
                r_mag_in1 <= req_input_1[w_grant*INPUT_BITS +: INPUT_BITS];
                r_mag_in2 <= req_input_2[w_grant*INPUT_BITS +: INPUT_BITS];
                r_ptr     <= (w_grant == CW'(NUM_CHANNELS - 1)) ? '0 : w_grant + 1'b1;
            end
            r_res_valid <= w_pop ? (NUM_CHANNELS'(1) << w_tag) : '0;
            if (w_pop) begin
                r_res_data <= mag_output_1;
                r_res_chan <= w_tag;
            end
            // A result with no outstanding tag is dropped and flagged
            if (mag_output_ready && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mag_input_ready = r_mag_rdy;
    assign mag_input_1     = r_mag_in1;
    assign mag_input_2     = r_mag_in2;
    assign res_valid       = r_res_valid;
    assign res_data        = r_res_data;
    assign res_channel     = r_res_chan;
    assign err_underflow   = r_err;
    assign idle            = (w_count == '0) && !r_mag_rdy;

endmodule
`default_nettype wire

// File: tb/tb_magnitude_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_magnitude_scheduler                                                     |
// | Scoreboard bench: reference arbiter model plus a queue-based magnitude stub.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_magnitude_scheduler;

    localparam int N     = 4;
    localparam int IB    = 16;
    localparam int OB    = IB + 1;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            sched_en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*IB-1:0] req_input_1 = '0;
    logic [N*IB-1:0] req_input_2 = '0;
    logic            mag_input_ready;
    logic [IB-1:0]   mag_input_1;
    logic [IB-1:0]   mag_input_2;
    logic            mag_output_ready;
    logic [OB-1:0]   mag_output_1;
    logic [N-1:0]    res_valid;
    logic [OB-1:0]   res_data;
    logic [1:0]      res_channel;
    logic            idle;
    logic            err_underflow;

    magnitude_scheduler #(
        .NUM_CHANNELS   (N),
        .INPUT_BITS     (IB),
        .OUTPUT_BITS    (OB),
        .TAG_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sched_en         (sched_en),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_input_1      (req_input_1),
        .req_input_2      (req_input_2),
        .mag_input_ready  (mag_input_ready),
        .mag_input_1      (mag_input_1),
        .mag_input_2      (mag_input_2),
        .mag_output_ready (mag_output_ready),
        .mag_output_1     (mag_output_1),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .res_channel      (res_channel),
        .idle             (idle),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OB-1:0] isqrt(input logic [IB-1:0] a, input logic [IB-1:0] b);
        longint s, r, t;
        s = longint'(a) * longint'(a) + longint'(b) * longint'(b);
        r = 0;
        for (int k = OB - 1; k >= 0; k--) begin
            t = r | (longint'(1) << k);
            if (t * t <= s) r = t;
        end
        return OB'(r);
    endfunction

    // Magnitude unit stand-in: in order, fixed latency unless held, shares reset
    typedef struct { logic [OB-1:0] data; int due; } pend_t;
    pend_t pipe_q[$];
    int    cyc;
    logic  hold = 1'b0;
    logic  inj  = 1'b0;

    initial begin
        mag_output_ready = 1'b0;
        mag_output_1     = '0;
        cyc              = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pipe_q.delete();
                mag_output_ready <= 1'b0;
                mag_output_1     <= '0;
                cyc              <= 0;
            end else begin
                cyc <= cyc + 1;
                if (!hold && pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
                    mag_output_ready <= 1'b1;
                    mag_output_1     <= pipe_q[0].data;
                    void'(pipe_q.pop_front());
                end else if (inj) begin
                    mag_output_ready <= 1'b1;
                    mag_output_1     <= '1;
                end else begin
                    mag_output_ready <= 1'b0;
                end
                if (mag_input_ready) pipe_q.push_back('{data: isqrt(mag_input_1, mag_input_2), due: cyc + 1});
            end
        end
    end

    // Reference model: round-robin pick from the spec rules, in-flight count, sticky error
    typedef struct { int ch; logic [OB-1:0] data; } exp_t;
    exp_t sb_q[$];
    int   grant_log[$];
    logic [OB-1:0] res_log[$];
    int   m_ptr, m_count, wait_cnt[N];
    logic m_issue, m_err;
    logic fair_chk = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_ptr = 0; m_count = 0; m_issue = 1'b0; m_err = 1'b0;
                sb_q.delete();
                for (int c = 0; c < N; c++) wait_cnt[c] = 0;
            end else begin
                int g, popped;
                logic [N-1:0] exp_rdy;
                g = -1;
                if (sched_en && m_count < DEPTH)
                    for (int k = 0; k < N; k++)
                        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                check("req_ready", 64'(req_ready), 64'(exp_rdy));
                check("idle", 64'(idle), 64'((m_count == 0) && !m_issue));
                check("err_underflow", 64'(err_underflow), 64'(m_err));
                for (int c = 0; c < N; c++) begin
                    if (c == g) begin
                        if (fair_chk) check("max_wait", 64'(wait_cnt[c] <= N - 1), 64'(1));
                        wait_cnt[c] = 0;
                    end else if (req_valid[c]) wait_cnt[c]++;
                    else wait_cnt[c] = 0;
                end
                if (g >= 0) begin
                    sb_q.push_back('{ch: g, data: isqrt(req_input_1[g*IB +: IB], req_input_2[g*IB +: IB])});
                    grant_log.push_back(g);
                    m_ptr = (g + 1) % N;
                end
                popped = (mag_output_ready && m_count > 0) ? 1 : 0;
                if (mag_output_ready && m_count == 0) m_err = 1'b1;
                m_count = m_count + ((g >= 0) ? 1 : 0) - popped;
                m_issue = (g >= 0);
            end
        end
    end

    // Monitor: every presented result must match the oldest outstanding grant
    initial begin
        forever begin
            @(negedge clk);
            if (rst && res_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("res_unexpected", 64'(res_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("res_valid", 64'(res_valid), 64'(1) << e.ch);
                    check("res_data", 64'(res_data), 64'(e.data));
                    check("res_channel", 64'(res_channel), 64'(e.ch));
                    res_log.push_back(res_data);
                end
            end
        end
    end

    task automatic set_pair(input int c, input logic [IB-1:0] a, input logic [IB-1:0] b);
        req_input_1[c*IB +: IB] = a;
        req_input_2[c*IB +: IB] = b;
    endtask

    task automatic rand_data();
        for (int c = 0; c < N; c++) set_pair(c, IB'($urandom), IB'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_until_accepts(input int n, input int budget, output int got);
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) got++;
        end
        @(posedge clk); #1;
    endtask

    task automatic count_accepts(input int cycles, output int got);
        got = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) got++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got, pulses, seen;
        logic [OB-1:0] data;
        logic [N-1:0]  vec;
        logic [1:0]    ch;
        logic [OB-1:0] exp_mag [4];

        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_mag_input_ready", 64'(mag_input_ready), 64'(0));
        check("rst_mag_input_1", 64'(mag_input_1), 64'(0));
        check("rst_mag_input_2", 64'(mag_input_2), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_res_channel", 64'(res_channel), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_err", 64'(err_underflow), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single request on channel 0
        sched_en = 1'b1;
        set_pair(0, 16'd3, 16'd4);
        req_valid = 4'b0001;
        run_until_accepts(1, 10, got);
        req_valid = '0;
        check("t1_accepts", 64'(got), 64'(1));
        pulses = 0; seen = 0; data = '0; vec = '0; ch = '0;
        repeat (10) begin
            @(negedge clk);
            if (mag_input_ready) pulses++;
            if (res_valid != '0) begin
                seen++; data = res_data; vec = res_valid; ch = res_channel;
            end
        end
        check("t1_issue_pulses", 64'(pulses), 64'(1));
        check("t1_results", 64'(seen), 64'(1));
        check("t1_res_valid", 64'(vec), 64'(4'b0001));
        check("t1_res_data", 64'(data), 64'(5));
        check("t1_res_channel", 64'(ch), 64'(0));
        @(posedge clk); #1;

        // All channels streaming
        do_reset();
        grant_log.delete(); res_log.delete();
        set_pair(0, 16'd5, 16'd12);
        set_pair(1, 16'd8, 16'd15);
        set_pair(2, 16'd0, 16'd0);
        set_pair(3, 16'd65535, 16'd0);
        exp_mag[0] = 17'd13; exp_mag[1] = 17'd17; exp_mag[2] = 17'd0; exp_mag[3] = 17'd65535;
        req_valid = 4'b1111;
        run_until_accepts(8, 20, got);
        req_valid = '0;
        idle_cycles(10);
        check("t2_accepts", 64'(got), 64'(8));
        check("t2_grant_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) check("t2_grant_order", 64'(grant_log[i]), 64'(i % N));
        check("t2_result_count", 64'(res_log.size()), 64'(8));
        for (int i = 0; i < 4; i++) check("t2_result_value", 64'(res_log[i]), 64'(exp_mag[i]));

        // Fairness with channel 0 bursting against two always-valid channels
        fair_chk = 1'b1;
        repeat (200) begin
            rand_data();
            req_valid = {2'b11, 1'b0, 1'($urandom_range(0, 1))};
            @(posedge clk); #1;
        end
        fair_chk = 1'b0;
        req_valid = '0;
        idle_cycles(10);

        // Random traffic with sched_en toggling
        repeat (300) begin
            rand_data();
            req_valid = N'($urandom);
            sched_en  = ($urandom_range(0, 9) != 0);
            @(posedge clk); #1;
        end
        req_valid = '0;
        sched_en  = 1'b1;
        idle_cycles(10);
        check("t4_drained", 64'(sb_q.size()), 64'(0));

        // Tag FIFO full with results held off
        hold = 1'b1;
        rand_data();
        req_valid = 4'b1111;
        count_accepts(10, got);
        check("t5_accepts_to_full", 64'(got), 64'(DEPTH));
        hold = 1'b0;
        @(posedge clk); #1 hold = 1'b1;
        count_accepts(6, got);
        check("t5_accepts_after_pop", 64'(got), 64'(1));
        req_valid = '0;
        hold = 1'b0;
        idle_cycles(15);
        check("t5_drained", 64'(sb_q.size()), 64'(0));

        // Result strobe with nothing in flight
        check("t6_err_before", 64'(err_underflow), 64'(0));
        inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_err_set", 64'(err_underflow), 64'(1));
        check("t6_res_valid", 64'(res_valid), 64'(0));
        repeat (5) @(negedge clk);
        check("t6_err_sticky", 64'(err_underflow), 64'(1));
        @(posedge clk); #1;

        // Asynchronous reset with samples in flight
        do_reset();
        hold = 1'b1;
        set_pair(0, 16'd300, 16'd400);
        req_valid = 4'b0001;
        run_until_accepts(3, 10, got);
        req_valid = '0;
        check("t7_in_flight", 64'(got), 64'(3));
        #2 rst = 1'b0;
        #1;
        check("t7_mag_input_ready", 64'(mag_input_ready), 64'(0));
        check("t7_mag_input_1", 64'(mag_input_1), 64'(0));
        check("t7_res_valid", 64'(res_valid), 64'(0));
        check("t7_res_data", 64'(res_data), 64'(0));
        check("t7_idle", 64'(idle), 64'(1));
        check("t7_err", 64'(err_underflow), 64'(0));
        hold = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        grant_log.delete();
        req_valid = 4'b0110;
        run_until_accepts(2, 10, got);
        req_valid = '0;
        check("t7_accepts", 64'(got), 64'(2));
        check("t7_first_grant", 64'(grant_log[0]), 64'(1));
        check("t7_second_grant", 64'(grant_log[1]), 64'(2));
        idle_cycles(10);
        check("final_drained", 64'(sb_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
